// File: rtl/tl_source_echo_responder.sv
// In-order TileLink-style A/D responder stub: echoes a_source, Put writes and Get reads one data register.
// Optional macro TL_RESPONDER_STALL_EN adds LFSR-driven pseudo-random A-channel backpressure.
module tl_source_echo_responder #(
  parameter int SOURCE_W = 4,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 4,
  parameter int LATENCY  = 2
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       a_valid,
  output logic                       a_ready,
  input  logic                       a_opcode,
  input  logic [SOURCE_W-1:0]        a_source,
  input  logic [DATA_W-1:0]          a_data,
  output logic                       d_valid,
  input  logic                       d_ready,
  output logic                       d_opcode,
  output logic [SOURCE_W-1:0]        d_source,
  output logic [DATA_W-1:0]          d_data,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     outstanding
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [3:0] CD_INIT = 4'(LATENCY - 1);

  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [DATA_W-1:0]   data_reg_q, data_reg_d;

  // Each entry holds the ready-to-send response (d_opcode, not a_opcode) plus its age countdown.
  logic                ent_op_q   [DEPTH];
  logic                ent_op_d   [DEPTH];
  logic [SOURCE_W-1:0] ent_src_q  [DEPTH];
  logic [SOURCE_W-1:0] ent_src_d  [DEPTH];
  logic [DATA_W-1:0]   ent_data_q [DEPTH];
  logic [DATA_W-1:0]   ent_data_d [DEPTH];
  logic [3:0]          ent_cd_q   [DEPTH];
  logic [3:0]          ent_cd_d   [DEPTH];

  logic full, enq, deq;

  // Handshakes: a transfer happens on a rising edge where valid & ready; a valid
  // source holds its payload stable until then, and ready never depends on valid.
  assign full = (count_q == CW'(DEPTH));

`ifdef TL_RESPONDER_STALL_EN
  logic [7:0] lfsr_q, lfsr_d;
  assign lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign a_ready = !full && !lfsr_q[0];
`else
  assign a_ready = !full;
`endif

  assign d_valid     = (count_q != '0) && (ent_cd_q[rd_ptr_q] == 4'd0);
  assign d_opcode    = d_valid ? ent_op_q[rd_ptr_q]   : 1'b0;
  assign d_source    = d_valid ? ent_src_q[rd_ptr_q]  : '0;
  assign d_data      = d_valid ? ent_data_q[rd_ptr_q] : '0;
  assign busy        = (count_q != '0);
  assign outstanding = count_q;

  assign enq = a_valid && a_ready;
  assign deq = d_valid && d_ready;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_reg_d = data_reg_q;
    ent_op_d   = ent_op_q;
    ent_src_d  = ent_src_q;
    ent_data_d = ent_data_q;
    ent_cd_d   = ent_cd_q;

    // Ageing runs regardless of D backpressure.
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_cd_q[i] != 4'd0) ent_cd_d[i] = ent_cd_q[i] - 4'd1;
    end

    if (enq) begin
      ent_op_d[wr_ptr_q]   = !a_opcode;
      ent_src_d[wr_ptr_q]  = a_source;
      ent_data_d[wr_ptr_q] = a_opcode ? '0 : data_reg_q;
      ent_cd_d[wr_ptr_q]   = CD_INIT;
      wr_ptr_d             = wr_ptr_q + PW'(1);
      if (a_opcode) data_reg_d = a_data;
    end

    if (deq) rd_ptr_d = rd_ptr_q + PW'(1);

    case ({enq, deq})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_reg_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_op_q[i]   <= 1'b0;
        ent_src_q[i]  <= '0;
        ent_data_q[i] <= '0;
        ent_cd_q[i]   <= 4'd0;
      end
`ifdef TL_RESPONDER_STALL_EN
      lfsr_q <= 8'hA5;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_reg_q <= data_reg_d;
      ent_op_q   <= ent_op_d;
      ent_src_q  <= ent_src_d;
      ent_data_q <= ent_data_d;
      ent_cd_q   <= ent_cd_d;
`ifdef TL_RESPONDER_STALL_EN
      lfsr_q <= lfsr_d;
`endif
    end
  end

endmodule

// File: tb/tb_tl_source_echo_responder.sv
// Self-checking bench for tl_source_echo_responder: directed scenarios plus randomized traffic
// compared against a queue-based timing model.
module tb_tl_source_echo_responder;
  localparam int SOURCE_W = 4;
  localparam int DATA_W   = 32;
  localparam int DEPTH    = 4;
  localparam int LATENCY  = 2;
  localparam int OW       = $clog2(DEPTH) + 1;

  logic                clock = 1'b0;
  logic                reset_n = 1'b0;
  logic                a_valid = 1'b0;
  logic                a_ready;
  logic                a_opcode = 1'b0;
  logic [SOURCE_W-1:0] a_source = '0;
  logic [DATA_W-1:0]   a_data = '0;
  logic                d_valid;
  logic                d_ready = 1'b0;
  logic                d_opcode;
  logic [SOURCE_W-1:0] d_source;
  logic [DATA_W-1:0]   d_data;
  logic                busy;
  logic [OW-1:0]       outstanding;

  int n_checks = 0;
  int n_pass   = 0;

  tl_source_echo_responder #(
    .SOURCE_W(SOURCE_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .LATENCY(LATENCY)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_source(a_source), .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_source(d_source), .d_data(d_data),
    .busy(busy), .outstanding(outstanding)
  );

  always #5 clock = ~clock;

  // Reference model: queue of expected responses, each with the cycle number it becomes visible.
  typedef struct {
    logic                op;
    logic [SOURCE_W-1:0] src;
    logic [DATA_W-1:0]   data;
    int unsigned         rdy;
  } exp_t;

  exp_t            exp_q[$];
  logic [DATA_W-1:0] m_data = '0;
  logic [7:0]      m_lfsr = 8'hA5;
  int unsigned     cyc = 0;
  bit              m_acc = 1'b0;
  bit              do_deq, do_acc;

  function automatic bit e_dvalid();
    return (exp_q.size() != 0) && (cyc >= exp_q[0].rdy);
  endfunction

  function automatic bit e_aready();
`ifdef TL_RESPONDER_STALL_EN
    return (exp_q.size() != DEPTH) && !m_lfsr[0];
`else
    return exp_q.size() != DEPTH;
`endif
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      exp_q.delete();
      m_data = '0;
      m_lfsr = 8'hA5;
      m_acc  = 1'b0;
    end else begin
      do_deq = e_dvalid() && d_ready;
      do_acc = a_valid && e_aready();
      cyc++;
      if (do_deq) void'(exp_q.pop_front());
      if (do_acc) begin
        exp_q.push_back('{!a_opcode, a_source, a_opcode ? '0 : m_data, cyc + LATENCY - 1});
        if (a_opcode) m_data = a_data;
      end
      m_acc  = do_acc;
      m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
  end

  // Called at a falling edge; returns at the falling edge after the model saw the handshake.
  task automatic send(input logic op, input logic [SOURCE_W-1:0] src, input logic [DATA_W-1:0] dat);
    a_valid = 1'b1; a_opcode = op; a_source = src; a_data = dat;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (m_acc) begin a_valid = 1'b0; return; end
    end
    n_checks++; $display("FAIL send_timeout: src %0d not accepted within 50 cycles", src);
    a_valid = 1'b0;
  endtask

  task automatic drain();
    d_ready = 1'b1; a_valid = 1'b0;
    repeat (LATENCY + DEPTH + 2) @(negedge clock);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    n_checks++; if (d_valid !== 1'b0 || d_source !== '0 || d_data !== '0) $display("FAIL reset_d_outputs: got v=%0b src=%0h data=%0h, want 0", d_valid, d_source, d_data); else n_pass++;
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      n_checks++; if (a_ready !== e_aready()) $display("FAIL idle_a_ready: got %0b want %0b", a_ready, e_aready()); else n_pass++;
      n_checks++; if (d_valid !== 1'b0) $display("FAIL idle_d_valid: got %0b want 0", d_valid); else n_pass++;
      n_checks++; if (busy !== 1'b0 || outstanding !== '0) $display("FAIL idle_busy: got busy=%0b out=%0d want 0/0", busy, outstanding); else n_pass++;
    end
  endtask

  task automatic test_put_get();
    int waits;
    drain();
    send(1'b1, 4'd3, 32'hDEADBEEF);
    send(1'b0, 4'd5, 32'h0);
    waits = 0;
    while (d_valid !== 1'b1 && waits < 20) begin @(negedge clock); waits++; end
`ifndef TL_RESPONDER_STALL_EN
    n_checks++; if (waits !== 0) $display("FAIL put_ack_latency: got %0d extra cycles want 0", waits); else n_pass++;
`endif
    n_checks++; if (d_valid !== 1'b1 || d_opcode !== 1'b0 || d_source !== 4'd3 || d_data !== 32'h0) $display("FAIL put_ack: got v=%0b op=%0b src=%0d data=%0h want 1/0/3/0", d_valid, d_opcode, d_source, d_data); else n_pass++;
    @(negedge clock);
    n_checks++; if (d_valid !== 1'b1 || d_opcode !== 1'b1 || d_source !== 4'd5 || d_data !== 32'hDEADBEEF) $display("FAIL get_ack: got v=%0b op=%0b src=%0d data=%0h want 1/1/5/deadbeef", d_valid, d_opcode, d_source, d_data); else n_pass++;
    @(negedge clock);
    n_checks++; if (d_valid !== 1'b0 || busy !== 1'b0) $display("FAIL put_get_empty: got v=%0b busy=%0b want 0/0", d_valid, busy); else n_pass++;
  endtask

  task automatic test_fill();
    bit found;
    drain();
    d_ready = 1'b0;
    for (int s = 0; s < DEPTH; s++) send(1'b0, SOURCE_W'(s), '0);
    a_valid = 1'b1; a_opcode = 1'b0; a_source = 4'd4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_checks++; if (a_ready !== 1'b0 || outstanding !== OW'(DEPTH)) $display("FAIL fill_full: got rdy=%0b out=%0d want 0/%0d", a_ready, outstanding, DEPTH); else n_pass++;
    end
    d_ready = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      n_checks++; if (d_valid !== 1'b1 || d_source !== SOURCE_W'(k)) $display("FAIL fill_order: got v=%0b src=%0d want 1/%0d", d_valid, d_source, k); else n_pass++;
      @(negedge clock);
      if (m_acc) a_valid = 1'b0;
`ifndef TL_RESPONDER_STALL_EN
      if (k == 0) begin
        n_checks++; if (a_ready !== 1'b1) $display("FAIL fill_reopen: got a_ready=%0b want 1", a_ready); else n_pass++;
      end
`endif
    end
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (d_valid === 1'b1 && d_source === 4'd4) found = 1'b1;
      else begin @(negedge clock); if (m_acc) a_valid = 1'b0; end
    end
    a_valid = 1'b0;
    n_checks++; if (!found) $display("FAIL fill_late_src4: got no response for src 4 want one"); else n_pass++;
  endtask

  task automatic test_stability();
    logic [DATA_W-1:0] dat;
    int waits;
    drain();
    dat = $urandom;
    d_ready = 1'b0;
    send(1'b1, 4'd9, dat);
    send(1'b0, 4'd7, '0);
    waits = 0;
    while (d_valid !== 1'b1 && waits < 20) begin @(negedge clock); waits++; end
    for (int i = 0; i < 6; i++) begin
      n_checks++; if (d_valid !== 1'b1 || d_opcode !== 1'b0 || d_source !== 4'd9 || d_data !== '0) $display("FAIL stable_hold: cycle %0d got v=%0b op=%0b src=%0d data=%0h want 1/0/9/0", i, d_valid, d_opcode, d_source, d_data); else n_pass++;
      @(negedge clock);
    end
    d_ready = 1'b1;
    @(negedge clock);
    n_checks++; if (d_valid !== 1'b1 || d_opcode !== 1'b1 || d_source !== 4'd7 || d_data !== dat) $display("FAIL stable_next: got v=%0b op=%0b src=%0d data=%0h want 1/1/7/%0h", d_valid, d_opcode, d_source, d_data, dat); else n_pass++;
  endtask

  task automatic test_reset_mid();
    drain();
    d_ready = 1'b0;
    for (int s = 0; s < 3; s++) send(1'b0, SOURCE_W'(s + 10), '0);
    repeat (2) @(negedge clock);
    n_checks++; if (d_valid !== 1'b1 || outstanding !== OW'(3)) $display("FAIL mid_pre: got v=%0b out=%0d want 1/3", d_valid, outstanding); else n_pass++;
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (d_valid !== 1'b0 || outstanding !== '0 || busy !== 1'b0) $display("FAIL mid_async: got v=%0b out=%0d busy=%0b want 0/0/0", d_valid, outstanding, busy); else n_pass++;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    d_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      n_checks++; if (d_valid !== 1'b0 || outstanding !== '0) $display("FAIL mid_after: got v=%0b out=%0d want 0/0", d_valid, outstanding); else n_pass++;
    end
  endtask

  task automatic test_random();
    logic e_op;
    logic [SOURCE_W-1:0] e_src;
    logic [DATA_W-1:0] e_data;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      e_op   = e_dvalid() ? exp_q[0].op   : 1'b0;
      e_src  = e_dvalid() ? exp_q[0].src  : '0;
      e_data = e_dvalid() ? exp_q[0].data : '0;
      n_checks++; if (a_ready !== e_aready()) $display("FAIL rnd_a_ready: cyc %0d got %0b want %0b", cyc, a_ready, e_aready()); else n_pass++;
      n_checks++; if (d_valid !== e_dvalid()) $display("FAIL rnd_d_valid: cyc %0d got %0b want %0b", cyc, d_valid, e_dvalid()); else n_pass++;
      if (e_dvalid()) begin
        n_checks++; if (d_opcode !== e_op || d_source !== e_src || d_data !== e_data) $display("FAIL rnd_d_payload: cyc %0d got op=%0b src=%0d data=%0h want %0b/%0d/%0h", cyc, d_opcode, d_source, d_data, e_op, e_src, e_data); else n_pass++;
      end
      n_checks++; if (outstanding !== OW'(exp_q.size()) || busy !== (exp_q.size() != 0)) $display("FAIL rnd_count: cyc %0d got out=%0d busy=%0b want %0d", cyc, outstanding, busy, exp_q.size()); else n_pass++;
      if (!a_valid || m_acc || $urandom_range(0, 3) == 0) begin
        a_valid  = ($urandom_range(0, 3) != 0);
        a_opcode = $urandom_range(0, 1);
        a_source = SOURCE_W'($urandom);
        a_data   = $urandom;
      end
      d_ready = ($urandom_range(0, 3) != 0);
    end
    a_valid = 1'b0;
  endtask

`ifdef TL_RESPONDER_STALL_EN
  task automatic test_stall();
    int sent, resp, gaps;
    drain();
    sent = 0; resp = 0; gaps = 0;
    a_valid = 1'b1; a_opcode = 1'b1; a_source = '0; a_data = $urandom;
    for (int i = 0; i < 600 && resp < 64; i++) begin
      @(negedge clock);
      if (m_acc) begin
        sent++;
        a_source = SOURCE_W'(sent);
        a_data   = $urandom;
        if (sent == 64) a_valid = 1'b0;
      end
      n_checks++; if (a_ready !== e_aready()) $display("FAIL stall_a_ready: cyc %0d got %0b want %0b", cyc, a_ready, e_aready()); else n_pass++;
      if (a_valid && a_ready === 1'b0 && exp_q.size() != DEPTH) gaps++;
      if (d_valid === 1'b1) begin
        n_checks++; if (d_source !== SOURCE_W'(resp) || d_opcode !== 1'b0) $display("FAIL stall_order: got src=%0d op=%0b want %0d/0", d_source, d_opcode, resp % 16); else n_pass++;
        resp++;
      end
    end
    a_valid = 1'b0;
    n_checks++; if (resp != 64) $display("FAIL stall_count: got %0d responses want 64", resp); else n_pass++;
    n_checks++; if (gaps == 0) $display("FAIL stall_gaps: got 0 backpressure cycles want >0"); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_put_get();
    test_fill();
    test_stability();
    test_reset_mid();
    test_random();
`ifdef TL_RESPONDER_STALL_EN
    test_stall();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
